// File: rtl/stepper_pkg.sv
// Shared types and helpers for the multi-channel stepper controller.
package stepper_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StDirSetup,
      StStepHigh,
      StStepLow
   } step_state_t;

   // dir level that means clockwise on the driver pin
   localparam logic DIR_CW = 1'b1;

   // Clamp a + b to the symmetric range +/-(2^(cnt_w-1)-1).
   function automatic int sat_add(input int a, input int b, input int unsigned cnt_w);
      int lim;
      int s;
      int r;
      lim = (1 << (cnt_w - 1)) - 1;
      s   = a + b;
      if (s > lim) begin
         r = lim;
      end else if (s < -lim) begin
         r = -lim;
      end else begin
         r = s;
      end
      return r;
   endfunction

endpackage

// File: rtl/step_channel.sv
// One stepper channel: saturating pending-step counter, step/dir FSM and phase timer.
module step_channel
   import stepper_pkg::*;
#(
   parameter int unsigned NUM_STEPS = 1,
   parameter int unsigned PULSE_LEN = 50000,
   parameter int unsigned DIR_SETUP = 100,
   parameter int unsigned CNT_W     = 8
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic cw_i,
   input  logic ccw_i,
   input  logic en_i,
   input  logic clr_sat_i,
   output logic dir_o,
   output logic step_o,
   output logic busy_o,
   output logic sat_o
);

   localparam int unsigned TmrMax = (PULSE_LEN > DIR_SETUP) ? PULSE_LEN : DIR_SETUP;
   localparam int unsigned TmrW   = (TmrMax > 1) ? $clog2(TmrMax) : 1;
   // Timers count down to zero, so a phase of N cycles loads N-1.
   localparam logic [TmrW-1:0] PulseLoad = TmrW'(PULSE_LEN - 1);
   localparam logic [TmrW-1:0] SetupLoad = TmrW'(DIR_SETUP - 1);

   step_state_t             state_q;
   logic [TmrW-1:0]         tmr_q;
   logic signed [CNT_W-1:0] pending_q;
   logic signed [CNT_W-1:0] pending_d;
   logic                    dir_q;
   logic                    step_q;
   logic                    busy_q;
   logic                    sat_q;

   logic pend_nz;
   logic pend_pos;
   logic dir_match;
   logic enter_high;
   logic going_idle;
   logic clip;
   int   add;
   int   cons;
   int   sum;
   int   clamped;

   // Request decode, consumption and saturating pending update.
   always_comb begin
      pend_nz   = (pending_q != '0);
      pend_pos  = pend_nz && !pending_q[CNT_W-1];
      dir_match = (pend_pos == (dir_q == DIR_CW));
      // A step starts from IDLE, or at the end of setup if the count still points the new way.
      enter_high = en_i && pend_nz && dir_match &&
                   ((state_q == StIdle) || ((state_q == StDirSetup) && (tmr_q == '0)));
      going_idle = ((state_q == StIdle) && !(en_i && pend_nz)) ||
                   ((state_q == StDirSetup) && (!en_i || ((tmr_q == '0) && !enter_high))) ||
                   ((state_q == StStepLow) && (tmr_q == '0));
      add = 0;
      if (cw_i && !ccw_i) begin
         add = int'(NUM_STEPS);
      end else if (ccw_i && !cw_i) begin
         add = -int'(NUM_STEPS);
      end
      cons = 0;
      if (enter_high) begin
         cons = (dir_q == DIR_CW) ? 1 : -1;
      end
      sum       = int'(pending_q) + add - cons;
      clamped   = sat_add(int'(pending_q), add - cons, CNT_W);
      clip      = en_i && (clamped != sum);
      pending_d = en_i ? clamped[CNT_W-1:0] : '0;
   end

   // Channel FSM with registered dir/step/busy/sat.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= StIdle;
         tmr_q     <= '0;
         pending_q <= '0;
         dir_q     <= 1'b0;
         step_q    <= 1'b0;
         busy_q    <= 1'b0;
         sat_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         // A fresh clip wins over a simultaneous clear.
         sat_q     <= clip | (sat_q & ~clr_sat_i);
         busy_q    <= !going_idle || (pending_d != '0);
         case (state_q)
            StIdle: begin
               if (enter_high) begin
                  state_q <= StStepHigh;
                  tmr_q   <= PulseLoad;
                  step_q  <= 1'b1;
               end else if (en_i && pend_nz) begin
                  dir_q   <= pend_pos ? DIR_CW : ~DIR_CW;
                  state_q <= StDirSetup;
                  tmr_q   <= SetupLoad;
               end
            end
            StDirSetup: begin
               if (!en_i) begin
                  state_q <= StIdle;
               end else if (tmr_q == '0) begin
                  if (enter_high) begin
                     state_q <= StStepHigh;
                     tmr_q   <= PulseLoad;
                     step_q  <= 1'b1;
                  end else begin
                     // Count was cancelled during setup: nothing left to step.
                     state_q <= StIdle;
                  end
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            StStepHigh: begin
               if (tmr_q == '0) begin
                  state_q <= StStepLow;
                  tmr_q   <= PulseLoad;
                  step_q  <= 1'b0;
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            StStepLow: begin
               if (tmr_q == '0) begin
                  state_q <= StIdle;
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
               step_q  <= 1'b0;
            end
         endcase
      end
   end

   assign dir_o  = dir_q;
   assign step_o = step_q;
   assign busy_o = busy_q;
   assign sat_o  = sat_q;

endmodule

// File: rtl/multi_stepper_ctrl.sv
// N independent stepper channels sharing clock, reset and the saturation clear.
module multi_stepper_ctrl #(
   parameter int unsigned NUM_CH    = 2,
   parameter int unsigned NUM_STEPS = 1,
   parameter int unsigned PULSE_LEN = 50000,
   parameter int unsigned DIR_SETUP = 100,
   parameter int unsigned CNT_W     = 8
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic [NUM_CH-1:0] cw,
   input  logic [NUM_CH-1:0] ccw,
   input  logic [NUM_CH-1:0] en,
   input  logic              clr_sat,
   output logic [NUM_CH-1:0] dir,
   output logic [NUM_CH-1:0] step,
   output logic [NUM_CH-1:0] busy,
   output logic [NUM_CH-1:0] sat
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      step_channel #(
         .NUM_STEPS(NUM_STEPS),
         .PULSE_LEN(PULSE_LEN),
         .DIR_SETUP(DIR_SETUP),
         .CNT_W    (CNT_W)
      ) u_ch (
         .clk_i    (CLOCK_50),
         .reset_i  (reset),
         .cw_i     (cw[i]),
         .ccw_i    (ccw[i]),
         .en_i     (en[i]),
         .clr_sat_i(clr_sat),
         .dir_o    (dir[i]),
         .step_o   (step[i]),
         .busy_o   (busy[i]),
         .sat_o    (sat[i])
      );
   end

endmodule

// File: tb/tb_multi_stepper_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_multi_stepper_ctrl;

   localparam int NUM_CH    = 2;
   localparam int NUM_STEPS = 2;
   localparam int PULSE_LEN = 4;
   localparam int DIR_SETUP = 3;
   localparam int CNT_W     = 4;
   localparam int LIM       = 7;

   localparam int PhIdle  = 0;
   localparam int PhSetup = 1;
   localparam int PhHigh  = 2;
   localparam int PhLow   = 3;

   logic              CLOCK_50 = 1'b0;
   logic              reset;
   logic [NUM_CH-1:0] cw;
   logic [NUM_CH-1:0] ccw;
   logic [NUM_CH-1:0] en;
   logic              clr_sat;
   logic [NUM_CH-1:0] dir;
   logic [NUM_CH-1:0] step;
   logic [NUM_CH-1:0] busy;
   logic [NUM_CH-1:0] sat;

   multi_stepper_ctrl #(
      .NUM_CH   (NUM_CH),
      .NUM_STEPS(NUM_STEPS),
      .PULSE_LEN(PULSE_LEN),
      .DIR_SETUP(DIR_SETUP),
      .CNT_W    (CNT_W)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .reset   (reset),
      .cw      (cw),
      .ccw     (ccw),
      .en      (en),
      .clr_sat (clr_sat),
      .dir     (dir),
      .step    (step),
      .busy    (busy),
      .sat     (sat)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Model: pending count, current phase with cycles left in it, dir and sticky flag.
   int m_pend  [NUM_CH];
   int m_phase [NUM_CH];
   int m_left  [NUM_CH];
   bit m_dir   [NUM_CH];
   bit m_sat   [NUM_CH];
   int m_edges [NUM_CH];
   int d_edges [NUM_CH];
   bit m_prev  [NUM_CH];
   bit d_prev  [NUM_CH];

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      for (int ch = 0; ch < NUM_CH; ch++) begin
         int a;
         int c;
         int s;
         bit clip;
         a    = 0;
         c    = 0;
         clip = 0;
         if (reset) begin
            m_pend[ch]  = 0;
            m_phase[ch] = PhIdle;
            m_left[ch]  = 0;
            m_dir[ch]   = 0;
            m_sat[ch]   = 0;
         end else begin
            if (en[ch]) begin
               if (cw[ch] && !ccw[ch]) a = NUM_STEPS;
               else if (ccw[ch] && !cw[ch]) a = -NUM_STEPS;
            end
            case (m_phase[ch])
               PhIdle: begin
                  if (en[ch] && m_pend[ch] != 0) begin
                     if ((m_pend[ch] > 0) == m_dir[ch]) begin
                        m_phase[ch] = PhHigh;
                        m_left[ch]  = PULSE_LEN;
                        c           = m_dir[ch] ? 1 : -1;
                     end else begin
                        m_dir[ch]   = (m_pend[ch] > 0);
                        m_phase[ch] = PhSetup;
                        m_left[ch]  = DIR_SETUP;
                     end
                  end
               end
               PhSetup: begin
                  if (!en[ch]) begin
                     m_phase[ch] = PhIdle;
                  end else if (m_left[ch] > 1) begin
                     m_left[ch]--;
                  end else if (m_pend[ch] != 0 && (m_pend[ch] > 0) == m_dir[ch]) begin
                     m_phase[ch] = PhHigh;
                     m_left[ch]  = PULSE_LEN;
                     c           = m_dir[ch] ? 1 : -1;
                  end else begin
                     m_phase[ch] = PhIdle;
                  end
               end
               PhHigh: begin
                  if (m_left[ch] > 1) begin
                     m_left[ch]--;
                  end else begin
                     m_phase[ch] = PhLow;
                     m_left[ch]  = PULSE_LEN;
                  end
               end
               default: begin
                  if (m_left[ch] > 1) m_left[ch]--;
                  else m_phase[ch] = PhIdle;
               end
            endcase
            s = m_pend[ch] + a - c;
            if (!en[ch]) begin
               m_pend[ch] = 0;
            end else if (s > LIM) begin
               m_pend[ch] = LIM;
               clip       = 1;
            end else if (s < -LIM) begin
               m_pend[ch] = -LIM;
               clip       = 1;
            end else begin
               m_pend[ch] = s;
            end
            if (clip) m_sat[ch] = 1;
            else if (clr_sat) m_sat[ch] = 0;
         end
      end
   endtask

   // One clock: model follows the edge, outputs compared 1 time unit later.
   task automatic tick();
      @(posedge CLOCK_50);
      model_edge();
      #1;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         bit es;
         bit eb;
         es = (m_phase[ch] == PhHigh);
         eb = (m_phase[ch] != PhIdle) || (m_pend[ch] != 0);
         check($sformatf("step%0d", ch), step[ch], es);
         check($sformatf("dir%0d", ch), dir[ch], m_dir[ch]);
         check($sformatf("busy%0d", ch), busy[ch], eb);
         check($sformatf("sat%0d", ch), sat[ch], m_sat[ch]);
         if (es && !m_prev[ch]) m_edges[ch]++;
         if (step[ch] && !d_prev[ch]) d_edges[ch]++;
         m_prev[ch] = es;
         d_prev[ch] = step[ch];
      end
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic clear_counts();
      for (int ch = 0; ch < NUM_CH; ch++) begin
         m_edges[ch] = 0;
         d_edges[ch] = 0;
      end
   endtask

   initial begin
      reset   = 1'b1;
      cw      = '0;
      ccw     = '0;
      en      = '1;
      clr_sat = 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         m_prev[ch] = 0;
         d_prev[ch] = 0;
      end
      run(3);
      check("reset_outs", {step, dir, busy, sat}, 8'h00);
      reset = 1'b0;
      run(2);

      // Single cw on ch0: dir rises, 3 setup cycles, two 4/4 pulses.
      clear_counts();
      cw[0] = 1'b1;
      tick();
      cw[0] = 1'b0;
      tick();
      check("s1_dir0_set", dir[0], 1'b1);
      run(3);
      check("s1_step0_after_setup", step[0], 1'b1);
      run(30);
      check("s1_steps0", d_edges[0], 2);
      check("s1_busy0", busy[0], 1'b0);
      check("s1_ch1_quiet", {step[1], dir[1], busy[1], sat[1]}, 4'h0);

      // Five consecutive cw on ch1: clamp at 7, sat sticks until cleared.
      clear_counts();
      cw[1] = 1'b1;
      run(5);
      cw[1] = 1'b0;
      check("s2_sat1", sat[1], 1'b1);
      run(100);
      check("s2_steps1_model", d_edges[1], m_edges[1]);
      check("s2_steps1", d_edges[1], 8);
      check("s2_sat1_held", sat[1], 1'b1);
      clr_sat = 1'b1;
      tick();
      clr_sat = 1'b0;
      check("s2_sat1_clr", sat[1], 1'b0);

      // cw and ccw together cancel.
      clear_counts();
      cw[0]  = 1'b1;
      ccw[0] = 1'b1;
      tick();
      cw[0]  = 1'b0;
      ccw[0] = 1'b0;
      run(5);
      check("s3_busy0", busy[0], 1'b0);
      check("s3_steps0", d_edges[0], 0);

      // Reversal during STEP_HIGH with pending +1.
      clear_counts();
      cw[0] = 1'b1;
      tick();
      cw[0] = 1'b0;
      tick();
      check("s4_high", step[0], 1'b1);
      ccw[0] = 1'b1;
      tick();
      ccw[0] = 1'b0;
      check("s4_dir_held", dir[0], 1'b1);
      run(40);
      check("s4_steps0", d_edges[0], 2);
      check("s4_dir0", dir[0], 1'b0);

      // en0 dropped mid-STEP_HIGH with |pending| = 3.
      clear_counts();
      ccw[0] = 1'b1;
      run(2);
      ccw[0] = 1'b0;
      check("s5_high", step[0], 1'b1);
      en[0] = 1'b0;
      run(20);
      check("s5_steps0", d_edges[0], 1);
      check("s5_dir0", dir[0], 1'b0);
      check("s5_busy0", busy[0], 1'b0);
      en[0] = 1'b1;
      run(2);

      // Reset mid-STEP_HIGH, then a fresh sequence.
      clear_counts();
      cw[0] = 1'b1;
      tick();
      cw[0] = 1'b0;
      run(4);
      check("s6_high", step[0], 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("s6_reset_outs", {step, dir, busy, sat}, 8'h00);
      cw[0] = 1'b1;
      tick();
      cw[0] = 1'b0;
      tick();
      check("s6_dir0_fresh", dir[0], 1'b1);
      check("s6_step0_setup", step[0], 1'b0);
      run(30);
      check("s6_steps0", d_edges[0], 3);

      // Random traffic against the model.
      clear_counts();
      for (int i = 0; i < 3000; i++) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            cw[ch]  = ($urandom_range(0, 7) == 0);
            ccw[ch] = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 63) == 0) en[ch] = ~en[ch];
         end
         clr_sat = ($urandom_range(0, 31) == 0);
         reset   = ($urandom_range(0, 499) == 0);
         tick();
      end
      cw      = '0;
      ccw     = '0;
      clr_sat = 1'b0;
      reset   = 1'b0;
      run(10);
      for (int ch = 0; ch < NUM_CH; ch++) begin
         check($sformatf("rnd_steps%0d", ch), d_edges[ch], m_edges[ch]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multi_stepper_ctrl.md
Name: multi_stepper_ctrl

Overview:
- N-channel successor to the single-axis stepper path.
- Each channel accepts single-cycle cw/ccw request pulses from an encoder down-sampler and accumulates them into a signed pending-step count that saturates at its limits.
- Each channel replays the count as A4988-style dir/step pulses with programmable pulse width and direction-setup time.
- Sits between the enc_down instances and the stepper driver pins in the top level.

Parameters:
- NUM_CH, 2, number of independent motor channels (1..8).
- NUM_STEPS, 1, motor steps added per cw/ccw request.
- PULSE_LEN, 50000, CLOCK_50 cycles for the step-high phase, and the minimum cycles for the step-low phase.
- DIR_SETUP, 100, CLOCK_50 cycles that dir must be stable before a step rises after a direction change.
- CNT_W, 8, width of the signed pending counter. Limits are ±(2^(CNT_W-1)-1).

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cw  in  NUM_CH  per-channel clockwise request, single-cycle pulse
- ccw  in  NUM_CH  per-channel counter-clockwise request, single-cycle pulse
- en  in  NUM_CH  per-channel enable
- clr_sat  in  1  clears all saturation flags
- dir  out  NUM_CH  driver direction; 1 = cw
- step  out  NUM_CH  driver step pulse
- busy  out  NUM_CH  channel has pending steps or is not in IDLE
- sat  out  NUM_CH  sticky flag: a request was clipped by saturation

Behaviour:
- Reset: all outputs are 0, every pending counter is 0, every FSM is in IDLE. Reset takes effect mid-pulse: step drops after the next edge.
- Channels are fully independent. There is no shared arbitration.
- Request decode, per cycle:
  - add = +NUM_STEPS if only cw is high; -NUM_STEPS if only ccw is high.
  - add = 0 if both or neither are high (simultaneous requests cancel).
- Consumption: cons = ±1 on the edge where the FSM enters STEP_HIGH, sign matching dir.
- Pending update: pending_next = clamp(pending + add - cons).
  - Compute at CNT_W+1 bits.
  - If clamping alters the value, set sat[i].
- Saturation flag: sat clears on reset or clr_sat. If clr_sat and a new saturation occur in the same cycle, sat stays set.
- en[i] = 0:
  - cw/ccw are ignored and pending is forced to 0.
  - A pulse already in STEP_HIGH or STEP_LOW completes, then the FSM returns to IDLE.
  - A channel in DIR_SETUP returns to IDLE immediately.
  - dir holds its value.
- FSM per channel: IDLE, DIR_SETUP, STEP_HIGH, STEP_LOW, driven by a PULSE_LEN/DIR_SETUP down-counter.
  - IDLE, pending == 0: stay.
  - IDLE, pending != 0, sign(pending) matches dir: go to STEP_HIGH. step goes to 1 and pending moves 1 toward 0 on the same edge.
  - IDLE, pending != 0, sign differs: dir is updated on this edge, then go to DIR_SETUP.
  - DIR_SETUP: step stays 0 for DIR_SETUP cycles, then go to STEP_HIGH.
  - STEP_HIGH: step = 1 for exactly PULSE_LEN cycles, then go to STEP_LOW.
  - STEP_LOW: step = 0 for exactly PULSE_LEN cycles, then go to IDLE. Re-evaluation happens in IDLE, so minimum step period = 2*PULSE_LEN + 1 cycles.
- Latency with no dir change: a request sampled at edge k makes pending nonzero after edge k, and step is high after edge k+1.
- dir changes only on IDLE→DIR_SETUP transitions, never during STEP_HIGH or STEP_LOW.
- A reversal arriving mid-pulse only changes pending. If pending crosses zero, the direction change happens at the next IDLE.
- busy = (state != IDLE) or (pending != 0).
- All outputs are registered.

Decomposition:
- Package stepper_pkg holds:
  - step_state_t enum (IDLE, DIR_SETUP, STEP_HIGH, STEP_LOW);
  - the DIR_CW = 1 constant;
  - a saturating add function parametrised by CNT_W.
- Sub-module step_channel holds the counter, FSM and timer for one channel. multi_stepper_ctrl is a generate loop of NUM_CH instances plus fan-out of the shared reset and clr_sat.

Test Plan:
Bench parameters: NUM_CH=2, NUM_STEPS=2, PULSE_LEN=4, DIR_SETUP=3, CNT_W=4 (limit ±7).
- Reset, then one cw pulse on ch0 → dir0 rises, 3 cycles of step0 low (DIR_SETUP), then 2 step pulses of 4 high / 4 low, then busy0 falls. ch1 outputs stay 0.
- Five cw pulses on ch1 in consecutive cycles → pending clamps at 7 and sat1 = 1. Exactly 7 steps are emitted (plus one more if consumption occurred before the clamp; the bench predicts this from the cycle-exact model). sat1 holds until a clr_sat pulse.
- cw and ccw high together on ch0 → pending unchanged, no step, busy0 stays 0.
- During ch0 STEP_HIGH with pending = +1, one ccw pulse → pending = -1. Current pulse completes 4/4, dir0 falls in IDLE, then 3 cycles of setup, then one step.
- en0 dropped mid-STEP_HIGH with pending = 3 → pulse completes to 4 high / 4 low, pending = 0, no further steps, dir0 unchanged.
- reset asserted mid-STEP_HIGH → step, dir, busy and sat are 0 after the next edge. A cw pulse issued after release produces a fresh DIR_SETUP sequence.
